// File: rtl/butterfly_r2_sdf.sv
`default_nettype none
// =====================================================================
// Module  : butterfly_r2_sdf
// Radix-2 DIF butterfly stage: buffers half a frame, pairs k with k+DATA/2.
// Rev 1.0 : initial release
// =====================================================================
module butterfly_r2_sdf #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 10,
  parameter int NUM       = 16,
  parameter int DATA      = 512
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM-1:0][IN_WIDTH-1:0]      din_i,
  input  logic [NUM-1:0][IN_WIDTH-1:0]      din_q,
  input  logic                              valid_in,
  input  logic                              scale_en,
  input  logic                              sat_clr,
  output logic [NUM-1:0][OUT_WIDTH-1:0]     do1_re,
  output logic [NUM-1:0][OUT_WIDTH-1:0]     do1_im,
  output logic [NUM-1:0][OUT_WIDTH-1:0]     do2_re,
  output logic [NUM-1:0][OUT_WIDTH-1:0]     do2_im,
  output logic                              valid_out,
  output logic [$clog2(DATA/2)-1:0]         out_base,
  output logic                              frame_last,
  output logic                              sat_flag
);

  localparam int HALF = DATA / 2;
  localparam int CYC  = HALF / NUM;
  localparam int IW   = $clog2(HALF);
  localparam int CW   = $clog2(2 * CYC);
  localparam int BW   = (CYC > 1) ? $clog2(CYC) : 1;
  localparam int RW   = IN_WIDTH + 2;
  localparam int EW   = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;

  localparam logic [0:0] c_st_fill = 1'b0;
  localparam logic [0:0] c_st_pair = 1'b1;

  localparam logic signed [EW-1:0] c_max = EW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] c_min = ~c_max;

  logic [0:0]                       r_state;
  logic [0:0]                       w_state_nxt;
  logic [CW-1:0]                    r_vec_cnt;
  logic                             r_scale;
  logic                             w_fill_we;
  logic                             w_pair_acc;
  logic                             w_last;
  logic [BW-1:0]                    w_idx;
  logic [NUM-1:0][IN_WIDTH-1:0]     r_buf_i [CYC];
  logic [NUM-1:0][IN_WIDTH-1:0]     r_buf_q [CYC];
  logic [NUM-1:0][IN_WIDTH-1:0]     w_rd_i;
  logic [NUM-1:0][IN_WIDTH-1:0]     w_rd_q;
  logic [NUM-1:0][OUT_WIDTH-1:0]    w_do1_re;
  logic [NUM-1:0][OUT_WIDTH-1:0]    w_do1_im;
  logic [NUM-1:0][OUT_WIDTH-1:0]    w_do2_re;
  logic [NUM-1:0][OUT_WIDTH-1:0]    w_do2_im;
  logic [NUM-1:0]                   w_lane_sat;

  function automatic logic signed [RW-1:0] ext(input logic [IN_WIDTH-1:0] x);
    return RW'(signed'(x));
  endfunction

  // Round half up before the arithmetic halving.
  function automatic logic signed [RW-1:0] rnd(input logic signed [RW-1:0] v,
                                               input logic sc);
    return sc ? ((v + RW'(1)) >>> 1) : v;
  endfunction

  // Returns {saturated, fitted value}.
  function automatic logic [OUT_WIDTH:0] fit(input logic signed [RW-1:0] v);
    logic signed [EW-1:0] e;
    e = EW'(v);
    if (e > c_max)
      return {1'b1, c_max[OUT_WIDTH-1:0]};
    else if (e < c_min)
      return {1'b1, c_min[OUT_WIDTH-1:0]};
    else
      return {1'b0, e[OUT_WIDTH-1:0]};
  endfunction

  assign w_last = (r_vec_cnt == CW'(2 * CYC - 1));
  assign w_idx  = (CYC > 1) ? r_vec_cnt[BW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= c_st_fill;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_fill: if (valid_in && (r_vec_cnt == CW'(CYC - 1))) w_state_nxt = c_st_pair;
      c_st_pair: if (valid_in && w_last) w_state_nxt = c_st_fill;
      default:   w_state_nxt = c_st_fill;
    endcase
  end

  always_comb begin
    w_fill_we  = 1'b0;
    w_pair_acc = 1'b0;
    case (r_state)
      c_st_fill: w_fill_we  = valid_in;
      c_st_pair: w_pair_acc = valid_in;
      default:   w_fill_we  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec_cnt <= '0;
      r_scale   <= 1'b0;
    end else if (valid_in) begin
      r_vec_cnt <= w_last ? '0 : r_vec_cnt + 1'b1;
      if (r_vec_cnt == '0)
        r_scale <= scale_en;
    end
  end

  // Same-frame reads always trail writes of the same slot by CYC vectors.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_buf_i[w_idx] <= din_i;
      r_buf_q[w_idx] <= din_q;
    end
  end

  assign w_rd_i = r_buf_i[w_idx];
  assign w_rd_q = r_buf_q[w_idx];

  for (genvar j = 0; j < NUM; j++) begin : g_lane
    logic signed [RW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic [OUT_WIDTH:0]   w_s_re, w_s_im, w_d_re, w_d_im;

    assign w_a_re = ext(w_rd_i[j]);
    assign w_a_im = ext(w_rd_q[j]);
    assign w_b_re = ext(din_i[j]);
    assign w_b_im = ext(din_q[j]);

    assign w_s_re = fit(rnd(w_a_re + w_b_re, r_scale));
    assign w_s_im = fit(rnd(w_a_im + w_b_im, r_scale));
    assign w_d_re = fit(rnd(w_a_re - w_b_re, r_scale));
    assign w_d_im = fit(rnd(w_a_im - w_b_im, r_scale));

    assign w_do1_re[j]   = w_s_re[OUT_WIDTH-1:0];
    assign w_do1_im[j]   = w_s_im[OUT_WIDTH-1:0];
    assign w_do2_re[j]   = w_d_re[OUT_WIDTH-1:0];
    assign w_do2_im[j]   = w_d_im[OUT_WIDTH-1:0];
    assign w_lane_sat[j] = w_s_re[OUT_WIDTH] | w_s_im[OUT_WIDTH] |
                           w_d_re[OUT_WIDTH] | w_d_im[OUT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      do1_re     <= '0;
      do1_im     <= '0;
      do2_re     <= '0;
      do2_im     <= '0;
      valid_out  <= 1'b0;
      out_base   <= '0;
      frame_last <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      valid_out  <= w_pair_acc;
      frame_last <= w_pair_acc && w_last;
      if (w_pair_acc) begin
        do1_re   <= w_do1_re;
        do1_im   <= w_do1_im;
        do2_re   <= w_do2_re;
        do2_im   <= w_do2_im;
        out_base <= IW'(w_idx) * IW'(NUM);
      end
      // A new saturation takes priority over a simultaneous clear.
      if (w_pair_acc && (|w_lane_sat))
        sat_flag <= 1'b1;
      else if (sat_clr)
        sat_flag <= 1'b0;
    end
  end

endmodule
`default_nettype wire
